hazard_unit_v2: RTL

- Parametrised successor to the RV32I pipeline hazard unit; sits beside the 5-stage datapath (F/D/E/M/W) and produces forwarding selects, stalls and flushes.
- New over the previous generation:
  - configurable load latency (1 or 2 cycles);
  - a registered peripheral-wait FSM with a bounded timeout;
  - x0-safe load-use detection;
  - an explicit M-stage bubble.

---
 rtl/hazard_unit_v2.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hazard_unit_v2.sv
// RV32I 5-stage hazard unit: forwarding selects, load-use/M-stage stalls, flushes and a
// peripheral-wait FSM with timeout. Optional perf counters behind `HAZ_PERF_CNT_EN.
module hazard_unit_v2 #(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int PER_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic              ResultSrcM0,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              IsPerM,
    input  logic              PENABLE,
    input  logic              proc_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              PerTimeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  LwStallCnt,
    output logic [CNT_W-1:0]  PerStallCnt,
    output logic [CNT_W-1:0]  FlushCnt
`endif
);

    localparam int WC_W = $clog2(PER_TIMEOUT + 2);

    typedef enum logic [1:0] {P_IDLE, P_WAIT, P_ERR} pstate_t;

    pstate_t         r_state, w_state_nxt;
    logic [WC_W-1:0] r_wcnt, w_wcnt_nxt;

    logic w_hit, w_lw_stall, w_m_stall, w_per_stall, w_m_fwd_ok, w_tmo;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rd_m,
                                           input logic [REG_AW-1:0] rd_w,
                                           input logic m_ok,
                                           input logic w_ok);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0 && rs == rd_m && m_ok)
            sel = 2'b10;
        else if (rs != '0 && rs == rd_w && w_ok)
            sel = 2'b01;
        return sel;
    endfunction

    // A 2-cycle load in M has no data yet; it falls through to W/regfile while mStall holds E.
    assign w_m_fwd_ok = RegWriteM && !((LOAD_LAT == 2) && ResultSrcM0);
    assign ForwardAE  = fwd_sel(Rs1E, RdM, RdW, w_m_fwd_ok, RegWriteW);
    assign ForwardBE  = fwd_sel(Rs2E, RdM, RdW, w_m_fwd_ok, RegWriteW);

    assign w_lw_stall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign w_m_stall  = (LOAD_LAT == 2) && ResultSrcM0 && RegWriteM && (RdM != '0) &&
                        ((Rs1E == RdM) || (Rs2E == RdM));

    assign w_hit       = PENABLE && proc_ready;
    assign w_tmo       = (PER_TIMEOUT != 0) && (r_wcnt == WC_W'(PER_TIMEOUT - 1));
    assign w_per_stall = IsPerM && !w_hit && (r_state != P_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= P_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            P_IDLE: begin
                if (IsPerM && !w_hit) begin
                    w_state_nxt = P_WAIT;
                    w_wcnt_nxt  = WC_W'(1);
                end
            end
            P_WAIT: begin
                if (!IsPerM || w_hit) begin
                    w_state_nxt = P_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (w_tmo) begin
                    w_state_nxt = P_ERR;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt  = r_wcnt + WC_W'(1);
                end
            end
            default: begin
                w_state_nxt = P_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    assign StallF     = w_lw_stall | w_m_stall | w_per_stall;
    assign StallD     = StallF;
    assign StallE     = w_m_stall | w_per_stall;
    assign StallM     = w_per_stall;
    // Branch flush is suppressed while E is held, so it fires once on the release cycle.
    assign FlushD     = PCSrcE && !StallE;
    assign FlushE     = (w_lw_stall || PCSrcE) && !StallE;
    assign FlushM     = w_m_stall && !w_per_stall;
    assign FlushW     = w_per_stall || (r_state == P_ERR);
    assign PerTimeout = (r_state == P_ERR);

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LwStallCnt  <= '0;
            PerStallCnt <= '0;
            FlushCnt    <= '0;
        end else begin
            if (w_lw_stall || w_m_stall) LwStallCnt  <= sat_inc(LwStallCnt);
            if (w_per_stall)             PerStallCnt <= sat_inc(PerStallCnt);
            if (FlushE)                  FlushCnt    <= sat_inc(FlushCnt);
        end
    end
`endif

endmodule
